top: RTL and testbench

TOP -- requirements
Module: top

---
 rtl/top.sv | 258 +++++++++++++++++++++++++
 tb/tb_top.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/top.sv
// Two-master / two-slave serial write bus driven by push-buttons.
// Each master sends one framed write per press: slave-select bit, address
// MSB first, then data MSB first, followed by a two-cycle acknowledge phase.

module bus_master #(
    parameter int                 DATA_W    = 8,
    parameter int                 ADDR_W    = 4,
    parameter logic [DATA_W-1:0]  DATA_INIT = '0
) (
    input  logic clock,
    input  logic rst,
    input  logic press,
    input  logic sel,
    input  logic gnt,
    input  logic ack,
    output logic req,
    output logic done,
    output logic bus_bit,
    output logic bus_cyc,
    output logic busy
);
    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);

    typedef enum logic [2:0] {IDLE, REQ, ADDR, DATA, ACK} state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic                 tgt;
    logic [ADDR_W-1:0]    addr;
    logic [DATA_W-1:0]    data;
    logic [FRAME_W-1:0]   shreg;

    assign req     = (state == REQ);
    assign bus_cyc = (state == ADDR) || (state == DATA);
    assign bus_bit = shreg[FRAME_W-1];
    assign done    = (state == ACK) && (cnt == CNT_W'(1));

    // Transaction sequencer: request, shift out the frame, wait out the ack phase.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
            tgt   <= 1'b0;
            addr  <= '0;
            data  <= DATA_INIT;
            shreg <= '1;
        end else begin
            case (state)
                IDLE: begin
                    if (press) begin
                        state <= REQ;
                        busy  <= 1'b1;
                        tgt   <= sel;
                    end
                end
                REQ: begin
                    if (gnt) begin
                        state <= ADDR;
                        shreg <= {tgt, addr, data};
                        cnt   <= '0;
                    end
                end
                ADDR: begin
                    shreg <= {shreg[FRAME_W-2:0], 1'b1};
                    if (cnt == CNT_W'(ADDR_W)) begin
                        state <= DATA;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    shreg <= {shreg[FRAME_W-2:0], 1'b1};
                    if (cnt == CNT_W'(DATA_W - 1)) begin
                        state <= ACK;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ACK: begin
                    if (done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                        if (ack) begin
                            addr <= addr + ADDR_W'(1);
                            data <= data + DATA_W'(1);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

module serial_slave #(
    parameter int   DATA_W = 8,
    parameter int   ADDR_W = 4,
    parameter logic SEL    = 1'b0
) (
    input  logic clock,
    input  logic rst,
    input  logic bus_line,
    input  logic bus_cyc,
    output logic ack
);
    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);

    logic [CNT_W-1:0]     cnt;
    logic [FRAME_W-2:0]   shreg;
    logic                 ack_pend;
    logic [DATA_W-1:0]    mem [2**ADDR_W];
    logic [FRAME_W-1:0]   frame;

    assign frame = {shreg, bus_line};

    // Frame receiver and register file; the ack reads back the stored word,
    // whose address/data stay in shreg until the next frame starts.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            shreg    <= '0;
            ack_pend <= 1'b0;
            ack      <= 1'b0;
            for (int unsigned i = 0; i < 2**ADDR_W; i++) begin
                mem[i] <= '0;
            end
        end else begin
            ack      <= ack_pend && (mem[shreg[DATA_W +: ADDR_W]] == shreg[DATA_W-1:0]);
            ack_pend <= 1'b0;
            if (bus_cyc) begin
                shreg <= frame[FRAME_W-2:0];
                if (cnt == CNT_W'(FRAME_W - 1)) begin
                    cnt <= '0;
                    if (frame[FRAME_W-1] == SEL) begin
                        mem[frame[DATA_W +: ADDR_W]] <= frame[DATA_W-1:0];
                        ack_pend <= 1'b1;
                    end
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end
endmodule

module top #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic clock,
    input  logic rst,
    input  logic ena,
    input  logic button1_val,
    input  logic button2_val,
    input  logic button1_sel,
    input  logic button2_sel,
    output logic m1_busy,
    output logic m2_busy
);
    localparam logic [DATA_W-1:0] M2_INIT = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {OWN_NONE, OWN_M1, OWN_M2} owner_t;

    logic [2:0] sync1, sync2;
    logic       press1, press2;
    logic       m1_req, m2_req, m1_done, m2_done;
    logic       m1_bit, m2_bit, m1_cyc, m2_cyc;
    logic       gnt1, gnt2, m1_ack, m2_ack;
    logic       s1_ack, s2_ack;
    logic       bus_line, bus_cyc;
    owner_t     owner;

    // Two-flop synchronizers plus one history flop for falling-edge detection.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= {sync1[1:0], button1_val};
            sync2 <= {sync2[1:0], button2_val};
        end
    end

    assign press1 = ena && sync1[2] && !sync1[1];
    assign press2 = ena && sync2[2] && !sync2[1];

    // A grant is decided and taken on the same edge, so REQ lasts one cycle when free.
    assign gnt1 = (owner == OWN_NONE) && m1_req;
    assign gnt2 = (owner == OWN_NONE) && m2_req && !m1_req;

    // Bus ownership: fixed priority to master 1, held until the owner leaves ACK.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            owner <= OWN_NONE;
        end else begin
            case (owner)
                OWN_NONE: begin
                    if (gnt1)      owner <= OWN_M1;
                    else if (gnt2) owner <= OWN_M2;
                end
                OWN_M1:  if (m1_done) owner <= OWN_NONE;
                OWN_M2:  if (m2_done) owner <= OWN_NONE;
                default: owner <= OWN_NONE;
            endcase
        end
    end

    // Shared serial line: owner's bit while framing, otherwise idle high.
    always_comb begin
        bus_cyc  = 1'b0;
        bus_line = 1'b1;
        case (owner)
            OWN_M1: begin
                bus_cyc  = m1_cyc;
                bus_line = m1_cyc ? m1_bit : 1'b1;
            end
            OWN_M2: begin
                bus_cyc  = m2_cyc;
                bus_line = m2_cyc ? m2_bit : 1'b1;
            end
            default: ;
        endcase
    end

    assign m1_ack = (owner == OWN_M1) && (s1_ack || s2_ack);
    assign m2_ack = (owner == OWN_M2) && (s1_ack || s2_ack);

    bus_master #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DATA_INIT('0)) u_master1 (
        .clock(clock), .rst(rst), .press(press1), .sel(button1_sel), .gnt(gnt1),
        .ack(m1_ack), .req(m1_req), .done(m1_done), .bus_bit(m1_bit),
        .bus_cyc(m1_cyc), .busy(m1_busy)
    );

    bus_master #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DATA_INIT(M2_INIT)) u_master2 (
        .clock(clock), .rst(rst), .press(press2), .sel(button2_sel), .gnt(gnt2),
        .ack(m2_ack), .req(m2_req), .done(m2_done), .bus_bit(m2_bit),
        .bus_cyc(m2_cyc), .busy(m2_busy)
    );

    serial_slave #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SEL(1'b0)) u_slave1 (
        .clock(clock), .rst(rst), .bus_line(bus_line), .bus_cyc(bus_cyc), .ack(s1_ack)
    );

    serial_slave #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SEL(1'b1)) u_slave2 (
        .clock(clock), .rst(rst), .bus_line(bus_line), .bus_cyc(bus_cyc), .ack(s2_ack)
    );
endmodule

// File: tb/tb_top.sv
// Scoreboard bench for the button-driven two-master serial write bus.
module tb_top;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int WORDS  = 2**ADDR_W;

    logic clock = 1'b0;
    logic rst   = 1'b1;
    logic ena   = 1'b1;
    logic button1_val = 1'b1, button2_val = 1'b1;
    logic button1_sel = 1'b0, button2_sel = 1'b0;
    logic m1_busy, m2_busy;

    top #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clock(clock), .rst(rst), .ena(ena),
        .button1_val(button1_val), .button2_val(button2_val),
        .button1_sel(button1_sel), .button2_sel(button2_sel),
        .m1_busy(m1_busy), .m2_busy(m2_busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        int len;
        int slv;
        int adr;
        int dat;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    int   checks   = 0;
    int   failures = 0;
    int   m_addr[2];
    int   m_data[2];
    int   mem_model[2][WORDS];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int busy(input int m);
        return (m == 0) ? int'(m1_busy) : int'(m2_busy);
    endfunction

    function automatic int dut_mem(input int s, input int a);
        logic [ADDR_W-1:0] ai;
        ai = ADDR_W'(a);
        if (s == 0) return int'(dut.u_slave1.mem[ai]);
        return int'(dut.u_slave2.mem[ai]);
    endfunction

    task automatic model_reset();
        m_addr[0] = 0;
        m_addr[1] = 0;
        m_data[0] = 0;
        m_data[1] = 1 << (DATA_W - 1);
        for (int s = 0; s < 2; s++)
            for (int a = 0; a < WORDS; a++) mem_model[s][a] = 0;
        q1.delete();
        q2.delete();
    endtask

    // Reference: a completed write stores the master's counters, then both advance.
    task automatic push(input int m, input int sel, input int len);
        exp_t e;
        e.len = len;
        e.slv = sel;
        e.adr = m_addr[m];
        e.dat = m_data[m];
        mem_model[sel][e.adr] = e.dat;
        m_addr[m] = (m_addr[m] + 1) % WORDS;
        m_data[m] = (m_data[m] + 1) % (1 << DATA_W);
        if (m == 0) q1.push_back(e);
        else        q2.push_back(e);
    endtask

    task automatic set_btn(input int m, input logic v);
        if (m == 0) button1_val = v;
        else        button2_val = v;
    endtask

    task automatic set_sel(input int m, input logic v);
        if (m == 0) button1_sel = v;
        else        button2_sel = v;
    endtask

    task automatic wait_rise(input int m);
        int seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clock);
            #1;
            if (busy(m) != 0) begin
                seen = 1;
                break;
            end
        end
        check($sformatf("busy_rise_m%0d", m + 1), seen, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((m1_busy || m2_busy) && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (n >= 200) check("idle_timeout", n, 0);
        repeat (4) @(negedge clock);
    endtask

    task automatic press_single(input int m, input int sel, input int hold, input int dtap);
        @(negedge clock);
        set_sel(m, logic'(sel));
        set_btn(m, 1'b0);
        push(m, sel, 16);
        wait_rise(m);
        check($sformatf("other_idle_m%0d", 2 - m), busy(1 - m), 0);
        repeat (hold) @(negedge clock);
        set_btn(m, 1'b1);
        if (dtap != 0) begin
            repeat (2) @(negedge clock);
            set_btn(m, 1'b0);
            repeat (2) @(negedge clock);
            set_btn(m, 1'b1);
        end
        wait_idle();
    endtask

    task automatic press_both(input int s1, input int s2, input int hold);
        @(negedge clock);
        button1_sel = logic'(s1);
        button2_sel = logic'(s2);
        button1_val = 1'b0;
        button2_val = 1'b0;
        push(0, s1, 16);
        push(1, s2, 32);
        wait_rise(0);
        check("both_m2_rises_with_m1", int'(m2_busy), 1);
        repeat (hold) @(negedge clock);
        button1_val = 1'b1;
        button2_val = 1'b1;
        wait_idle();
    endtask

    task automatic press_disabled(input int m);
        int seen = 0;
        @(negedge clock);
        ena = 1'b0;
        set_btn(m, 1'b0);
        repeat (8) begin
            @(negedge clock);
            if (m1_busy || m2_busy) seen = 1;
        end
        set_btn(m, 1'b1);
        repeat (4) @(negedge clock);
        ena = 1'b1;
        repeat (4) @(negedge clock);
        check("ena0_no_busy", seen, 0);
    endtask

    task automatic reset_mid(input int m, input int sel, input int dly);
        @(negedge clock);
        set_sel(m, logic'(sel));
        set_btn(m, 1'b0);
        push(m, sel, 16);
        wait_rise(m);
        repeat (dly) @(negedge clock);
        #2;
        set_btn(m, 1'b1);
        rst = 1'b0;
        #1;
        check("reset_m1_busy", int'(m1_busy), 0);
        check("reset_m2_busy", int'(m2_busy), 0);
        model_reset();
        check("reset_word_cleared", dut_mem(sel, 0), 0);
        repeat (3) @(negedge clock);
        rst = 1'b1;
        repeat (4) @(negedge clock);
    endtask

    // Monitor: measure each busy pulse and compare it and its stored word.
    initial begin
        int   len[2];
        int   prev[2];
        exp_t e;
        len[0] = 0; len[1] = 0;
        prev[0] = 0; prev[1] = 0;
        forever begin
            @(negedge clock);
            for (int m = 0; m < 2; m++) begin
                if (!rst) begin
                    len[m]  = 0;
                    prev[m] = 0;
                end else begin
                    if (busy(m) != 0) begin
                        len[m]++;
                    end else if (prev[m] != 0) begin
                        if ((m == 0 && q1.size() == 0) || (m == 1 && q2.size() == 0)) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_busy_m%0d: pulse of %0d cycles, none expected", m + 1, len[m]);
                        end else begin
                            e = (m == 0) ? q1.pop_front() : q2.pop_front();
                            check($sformatf("busy_len_m%0d", m + 1), len[m], e.len);
                            check($sformatf("word_m%0d_s%0d_a%0d", m + 1, e.slv + 1, e.adr),
                                  dut_mem(e.slv, e.adr), e.dat);
                        end
                        len[m] = 0;
                    end
                    prev[m] = busy(m);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        int kind, sel, sel2, m;
        model_reset();
        #1 rst = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_m1_busy_init", int'(m1_busy), 0);
        check("reset_m2_busy_init", int'(m2_busy), 0);
        rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("idle_no_busy", int'(m1_busy || m2_busy), 0);
        end

        press_single(0, 0, 10, 0);
        repeat (200) @(negedge clock);
        press_single(0, 1, 10, 0);
        press_single(1, 0, 10, 0);
        press_single(1, 1, 10, 0);
        press_both(0, 1, 10);
        press_disabled(0);
        reset_mid(0, 0, 6);

        for (int it = 0; it < 40; it++) begin
            kind = int'($urandom_range(0, 5));
            sel  = int'($urandom_range(0, 1));
            sel2 = int'($urandom_range(0, 1));
            m    = int'($urandom_range(0, 1));
            case (kind)
                0, 1: begin
                    if ($urandom_range(0, 1) == 1)
                        press_single(m, sel, int'($urandom_range(1, 6)), 1);
                    else
                        press_single(m, sel, int'($urandom_range(1, 20)), 0);
                end
                2, 3: press_both(sel, sel2, int'($urandom_range(1, 20)));
                4:    press_disabled(m);
                default: reset_mid(m, sel, int'($urandom_range(1, 14)));
            endcase
        end

        wait_idle();
        repeat (10) @(negedge clock);
        check("q1_drained", q1.size(), 0);
        check("q2_drained", q2.size(), 0);
        for (int s = 0; s < 2; s++)
            for (int a = 0; a < WORDS; a++)
                check($sformatf("final_mem_s%0d_a%0d", s + 1, a), dut_mem(s, a), mem_model[s][a]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
